// File: rtl/mips_fetch_unit_pkg.sv
// Shared defaults and opcode constants for the MIPS fetch/decode boundary.
// The fetch unit takes its parameter defaults from here; decode reuses the opcode set.
package mips_fetch_unit_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_INSTR_W  = 32;
    localparam int          DEF_DEPTH    = 4;
    localparam int          DEF_PC_STEP  = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_RTYPE  = 6'h00,
        OP_REGIMM = 6'h01,
        OP_J      = 6'h02,
        OP_JAL    = 6'h03,
        OP_BEQ    = 6'h04,
        OP_BNE    = 6'h05,
        OP_ADDIU  = 6'h09,
        OP_LUI    = 6'h0F,
        OP_LW     = 6'h23,
        OP_SW     = 6'h2B
    } opcode_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    // Counters that must hold 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Bundle of the fetch unit's memory-side and decode-side signals.
// master = fetch unit, slave = instruction memory plus decode/control.
interface mips_fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready. Responses carry no ready and arrive in request order.
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  inst_pc;
    logic [ADDR_W-1:0]  inst_pc_next;

    logic               pause;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, instruction, inst_pc, inst_pc_next,
        input  inst_ready, pause, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, instruction, inst_pc, inst_pc_next,
        output inst_ready, pause, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/mips_fetch_unit_fifo.sv
// Synchronous prefetch FIFO with flush; head is read straight from storage (no bypass),
// so a pushed entry becomes visible the cycle after its push.
module fetch_fifo
    import mips_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CW   = count_w(DEPTH),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues pipelined memory requests, tags responses with
// their issue address and buffers them for decode; supports pause and branch/jump redirect.
module mips_fetch_unit
    import mips_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter int                PC_STEP  = DEF_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    mips_fetch_unit_if.master bus
);

    localparam int CW = count_w(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      outstanding_nxt;
    logic [CW-1:0]      discard;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        in_use;

    logic               issue_ok;
    logic               issue;
    logic               rsp_ok;
    logic               rsp_drop;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;

    logic [ADDR_W-1:0]  tag_q [DEPTH];
    logic [PW-1:0]      tag_wr;
    logic [PW-1:0]      tag_rd;

    logic [FW-1:0]      head_data;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // FIFO space is reserved at issue time, so a response always finds a free slot.
    assign in_use   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign issue_ok = !bus.pause && !reset && !bus.redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign issue    = issue_ok && bus.imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_ok   = bus.imem_rsp_valid && (outstanding != '0);
    assign rsp_drop = rsp_ok && (discard != '0);
    assign push     = rsp_ok && (discard == '0) && !bus.redirect_valid && !fifo_full;
    assign pop      = bus.inst_valid && bus.inst_ready && !bus.pause && !bus.redirect_valid;

    assign outstanding_nxt = outstanding + CW'(issue) - CW'(rsp_ok);

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLOCK_50),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.imem_rsp_data, tag_q[tag_rd]}),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_instr, head_pc} = head_data;

    assign bus.imem_req_valid = issue_ok;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = !fifo_empty;
    assign bus.instruction    = fifo_empty ? '0 : head_instr;
    assign bus.inst_pc        = fifo_empty ? '0 : head_pc;
    assign bus.inst_pc_next   = fifo_empty ? '0 : head_pc + ADDR_W'(PC_STEP);

    // Every in-flight request at a redirect belongs to the old stream and must be discarded.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (issue)  tag_wr <= ptr_next(tag_wr);
            if (rsp_ok) tag_rd <= ptr_next(tag_rd);
            if (bus.redirect_valid) begin
                fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
                discard  <= outstanding_nxt;
            end else begin
                if (issue)    fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                if (rsp_drop) discard  <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (issue) tag_q[tag_wr] <= fetch_pc;
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: in-order memory model with programmable latency,
// scoreboard of expected instruction PCs consumed by a monitor on each decode pop.
module tb_mips_fetch_unit;

    localparam int AW = 32;
    localparam int IW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    mips_fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (4),
        .PC_STEP  (4),
        .RESET_PC (32'h0)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    int acc_cnt = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] pend_addr[$];
    int pend_due[$];
    int pop_cyc[$];

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + AW'(4);
        end
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b1;
        bus.pause = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        bus.imem_req_ready = 1'b0;
        repeat (5) step();
        mem_lat = lat;
        exp_q.delete();
    endtask

    task automatic release_reset();
        acc_cnt = 0;
        pop_cyc.delete();
        rst = 1'b0;
        bus.imem_req_ready = 1'b1;
    endtask

    task automatic wait_accepts(input string name, input int n);
        int k;
        k = 0;
        while (acc_cnt < n && k < 50) begin
            step();
            k++;
        end
        check(name, (acc_cnt >= n) ? 64'd1 : 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step();
            k++;
        end
        bus.inst_ready = 1'b0;
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Memory: one response per cycle, in order, mem_lat edges after acceptance.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (bus.imem_rsp_valid && pend_addr.size() != 0) begin
                pend_addr.delete(0);
                pend_due.delete(0);
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend_addr.push_back(bus.imem_req_addr);
                pend_due.push_back(cyc + mem_lat);
                acc_cnt++;
            end
            #1;
            if (pend_addr.size() != 0 && pend_due[0] <= cyc + 1) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data = mem_word(pend_addr[0]);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data = '0;
            end
        end
    end

    // Monitor: every decode pop must match the head of the expected stream.
    initial begin
        logic [AW-1:0] e;
        logic [AW-1:0] nx;
        forever begin
            @(negedge clk);
            if (!rst && bus.inst_valid && bus.inst_ready && !bus.pause && !bus.redirect_valid) begin
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %0h expected none", bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    nx = e + AW'(4);
                    check("inst_pc", 64'(bus.inst_pc), 64'(e));
                    check("instruction", 64'(bus.instruction), 64'(mem_word(e)));
                    check("inst_pc_next", 64'(bus.inst_pc_next), 64'(nx));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Test 1: reset values, first-fetch latency, zero-bubble streaming.
        do_reset(1);
        @(negedge clk);
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_instruction", 64'(bus.instruction), 64'd0);
        check("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
        check("rst_inst_pc_next", 64'(bus.inst_pc_next), 64'd0);
        step();
        release_reset();
        bus.inst_ready = 1'b1;
        push_range(32'h0, 8);
        @(negedge clk);
        check("t1_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("t1_req_addr", 64'(bus.imem_req_addr), 64'd0);
        @(negedge clk);
        check("t1_valid_lat1", 64'(bus.inst_valid), 64'd0);
        @(negedge clk);
        check("t1_valid_lat2", 64'(bus.inst_valid), 64'd1);
        wait_drain("t1_drain");
        check("t1_throughput", (pop_cyc.size() >= 8) ? 64'(pop_cyc[7] - pop_cyc[0]) : 64'hFFFF, 64'd7);

        // Test 2: decode stalled, issue stops at DEPTH, then stream resumes seamlessly.
        do_reset(1);
        release_reset();
        repeat (10) step();
        @(negedge clk);
        check("t2_accepts", 64'(acc_cnt), 64'd4);
        check("t2_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("t2_head_pc", 64'(bus.inst_pc), 64'd0);
        push_range(32'h0, 8);
        step();
        bus.inst_ready = 1'b1;
        wait_drain("t2_drain");

        // Test 3: redirect with two requests in flight on a 3-cycle memory.
        do_reset(3);
        release_reset();
        bus.inst_ready = 1'b1;
        wait_accepts("t3_accepts", 2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        push_range(32'h100, 4);
        @(negedge clk);
        check("t3_no_issue_on_redirect", 64'(bus.imem_req_valid), 64'd0);
        step();
        bus.redirect_valid = 1'b0;
        check("t3_accepts_held", 64'(acc_cnt), 64'd2);
        wait_drain("t3_drain");

        // Test 4: pause holds decode and issue while responses still land.
        do_reset(3);
        release_reset();
        bus.inst_ready = 1'b1;
        wait_accepts("t4_accepts", 2);
        bus.pause = 1'b1;
        repeat (6) step();
        @(negedge clk);
        check("t4_no_new_req", 64'(acc_cnt), 64'd2);
        check("t4_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("t4_inst_valid", 64'(bus.inst_valid), 64'd1);
        check("t4_head_pc", 64'(bus.inst_pc), 64'd0);
        push_range(32'h0, 6);
        step();
        bus.pause = 1'b0;
        wait_drain("t4_drain");

        // Test 5: redirect and pop in the same cycle on a full FIFO; PC wraps past the top.
        do_reset(1);
        release_reset();
        repeat (8) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        bus.inst_ready = 1'b1;
        push_range(32'hFFFF_FFFC, 4);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_flushed", 64'(bus.inst_valid), 64'd0);
        wait_drain("t5_drain");

        // Test 6: reset with three requests in flight; late responses must vanish.
        do_reset(3);
        release_reset();
        wait_accepts("t6_accepts", 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("t6_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("t6_instruction", 64'(bus.instruction), 64'd0);
        check("t6_inst_pc", 64'(bus.inst_pc), 64'd0);
        check("t6_inst_pc_next", 64'(bus.inst_pc_next), 64'd0);
        repeat (4) step();
        release_reset();
        bus.inst_ready = 1'b1;
        push_range(32'h0, 4);
        wait_drain("t6_drain");

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
